// File: rtl/chunked_ripple_adder.sv
// chunked_ripple_adder: WIDTH-bit add/subtract computed CHUNK bits per clock,
// LSB chunk first, with the inter-chunk carry held in a register. Operands are
// accepted and results delivered through valid/ready handshakes.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | ready for operands; sum/cout/overflow keep the last result
// RUN   | one chunk added per edge; sum is partially written
// DONE  | result valid and held until the consumer takes it
module chunked_ripple_adder #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int NCHUNK = WIDTH / CHUNK;
   // A one-chunk configuration still needs a one-bit index to stay legal.
   localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic [IW-1:0]    idx_q, idx_d;

   logic             last_chunk;
   logic [CHUNK-1:0] ch_a, ch_b, ch_s;
   logic             c_run, c_msb_in, c_out;

   assign last_chunk = (idx_q == IW'(NCHUNK - 1));

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (in_valid)   state_d = S_RUN;
         S_RUN:   if (last_chunk) state_d = S_DONE;
         S_DONE:  if (out_ready)  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Handshake outputs are pure decodes of the state register
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         S_IDLE:  in_ready  = 1'b1;
         S_DONE:  out_valid = 1'b1;
         default: ;
      endcase
   end

   // Select the operand chunk addressed by the chunk index
   always_comb begin
      ch_a = '0;
      ch_b = '0;
      for (int k = 0; k < NCHUNK; k++) begin
         if (idx_q == IW'(k)) begin
            ch_a = a_q[k*CHUNK +: CHUNK];
            ch_b = b_q[k*CHUNK +: CHUNK];
         end
      end
   end

   // CHUNK-cell ripple chain; the carry into the top cell feeds overflow
   always_comb begin
      c_run    = carry_q;
      c_msb_in = carry_q;
      ch_s     = '0;
      for (int i = 0; i < CHUNK; i++) begin
         if (i == CHUNK - 1) c_msb_in = c_run;
         ch_s[i] = ch_a[i] ^ ch_b[i] ^ c_run;
         c_run   = (ch_a[i] & ch_b[i]) | (c_run & (ch_a[i] ^ ch_b[i]));
      end
      c_out = c_run;
   end

   // Datapath next-state: capture on acceptance, accumulate chunks in RUN
   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      idx_d   = idx_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = sub ? ~b : b;
               carry_d = sub ? 1'b1 : cin;
               sum_d   = '0;
               cout_d  = 1'b0;
               ovf_d   = 1'b0;
               idx_d   = '0;
            end
         end
         S_RUN: begin
            for (int k = 0; k < NCHUNK; k++) begin
               if (idx_q == IW'(k)) sum_d[k*CHUNK +: CHUNK] = ch_s;
            end
            carry_d = c_out;
            if (last_chunk) begin
               idx_d  = '0;
               cout_d = c_out;
               ovf_d  = c_msb_in ^ c_out;
            end else begin
               idx_d  = idx_q + IW'(1);
            end
         end
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         idx_q   <= '0;
      end else begin
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         idx_q   <= idx_d;
      end
   end

   assign sum      = sum_q;
   assign cout     = cout_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_chunked_ripple_adder.sv
// Bench for chunked_ripple_adder: directed cases on a 32/4 instance plus a
// random sweep across four (WIDTH, CHUNK) configurations with a scoreboard.
module tb_chunked_ripple_adder;

   typedef struct packed {
      logic [31:0] s;
      logic        c;
      logic        v;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        iv_m, iv_s, or_m, or_s;
   logic [31:0] a_i, b_i;
   logic        cin_i, sub_i;

   logic        ir0, ov0, c0, v0;
   logic [31:0] s0;
   logic        ir1, ov1, c1, v1;
   logic [7:0]  s1;
   logic        ir2, ov2, c2, v2;
   logic [7:0]  s2;
   logic        ir3, ov3, c3, v3;
   logic [15:0] s3;

   logic [31:0] sw [4];
   logic [3:0]  cw, vw, ovv;

   exp_t q [4][$];
   int   W  [4] = '{32, 8, 8, 16};
   int   NC [4] = '{8, 8, 1, 4};

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   chunked_ripple_adder #(.WIDTH(32), .CHUNK(4)) u_dut (
      .clk(clk), .rst(rst), .in_valid(iv_m), .in_ready(ir0), .a(a_i), .b(b_i),
      .cin(cin_i), .sub(sub_i), .out_valid(ov0), .out_ready(or_m),
      .sum(s0), .cout(c0), .overflow(v0));

   chunked_ripple_adder #(.WIDTH(8), .CHUNK(1)) u_w8c1 (
      .clk(clk), .rst(rst), .in_valid(iv_s), .in_ready(ir1), .a(a_i[7:0]), .b(b_i[7:0]),
      .cin(cin_i), .sub(sub_i), .out_valid(ov1), .out_ready(or_s),
      .sum(s1), .cout(c1), .overflow(v1));

   chunked_ripple_adder #(.WIDTH(8), .CHUNK(8)) u_w8c8 (
      .clk(clk), .rst(rst), .in_valid(iv_s), .in_ready(ir2), .a(a_i[7:0]), .b(b_i[7:0]),
      .cin(cin_i), .sub(sub_i), .out_valid(ov2), .out_ready(or_s),
      .sum(s2), .cout(c2), .overflow(v2));

   chunked_ripple_adder #(.WIDTH(16), .CHUNK(4)) u_w16c4 (
      .clk(clk), .rst(rst), .in_valid(iv_s), .in_ready(ir3), .a(a_i[15:0]), .b(b_i[15:0]),
      .cin(cin_i), .sub(sub_i), .out_valid(ov3), .out_ready(or_s),
      .sum(s3), .cout(c3), .overflow(v3));

   assign sw[0] = s0;
   assign sw[1] = {24'b0, s1};
   assign sw[2] = {24'b0, s2};
   assign sw[3] = {16'b0, s3};
   assign cw    = {c3, c2, c1, c0};
   assign vw    = {v3, v2, v1, v0};
   assign ovv   = {ov3, ov2, ov1, ov0};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: w-bit add of a, (sub ? ~b : b) and carry, signed overflow
   // judged from operand and result signs.
   function automatic exp_t model(logic [31:0] a, logic [31:0] b, logic ci,
                                  logic sb, int w);
      exp_t        r;
      logic [32:0] mask, aa, bb, full;
      mask = (33'd1 << w) - 33'd1;
      aa   = {1'b0, a} & mask;
      bb   = (sb ? ~{1'b0, b} : {1'b0, b}) & mask;
      full = aa + bb + {32'd0, (sb ? 1'b1 : ci)};
      r.s  = full[31:0] & mask[31:0];
      r.c  = full[w];
      r.v  = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
      return r;
   endfunction

   task automatic run_main(logic [31:0] a, logic [31:0] b, logic ci, logic sb,
                           logic [31:0] es, logic ec, logic ev, bit release_it);
      int   n;
      exp_t e, r;
      e.s = es; e.c = ec; e.v = ev;
      a_i = a; b_i = b; cin_i = ci; sub_i = sb;
      iv_m = 1'b1;
      q[0].push_back(e);
      tick();
      iv_m = 1'b0;
      check("busy_in_ready", ir0, 1'b0);
      n = 0;
      while (ov0 !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      check("latency", n, 8);
      r = q[0].pop_front();
      check("sum", s0, r.s);
      check("cout", c0, r.c);
      check("overflow", v0, r.v);
      if (release_it) begin
         or_m = 1'b1;
         tick();
         or_m = 1'b0;
         check("release_in_ready", ir0, 1'b1);
         check("release_out_valid", ov0, 1'b0);
      end
   endtask

   initial begin
      int   n;
      logic [3:0] seen;
      exp_t r;

      rst = 1'b1; iv_m = 1'b0; iv_s = 1'b0; or_m = 1'b0; or_s = 1'b0;
      a_i = '0; b_i = '0; cin_i = 1'b0; sub_i = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check("rst_sum", s0, 0);
      check("rst_cout", c0, 0);
      check("rst_ovf", v0, 0);
      check("rst_out_valid", ov0, 0);
      check("rst_in_ready", ir0, 1);
      tick();
      check("idle_in_ready", ir0, 1);
      check("idle_out_valid", ov0, 0);

      run_main(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b1);
      run_main(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0001, 1'b1, 1'b0, 1'b1);
      run_main(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
      run_main(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
      run_main(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1);

      // Backpressure: result held in DONE while inputs churn
      run_main(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         a_i = $urandom; b_i = $urandom; sub_i = 1'(i); cin_i = 1'(i + 1);
         iv_m = 1'(i % 2);
         tick();
         check("hold_sum", s0, 32'h2345_6789);
         check("hold_out_valid", ov0, 1);
         check("hold_in_ready", ir0, 0);
      end
      iv_m = 1'b0;
      or_m = 1'b1;
      tick();
      or_m = 1'b0;
      check("bp_release_in_ready", ir0, 1);
      check("bp_release_out_valid", ov0, 0);
      tick();
      check("bp_no_accept", ir0, 1);

      // Reset with the chunk index at 3
      a_i = 32'hDEAD_BEEF; b_i = 32'h0F0F_0F0F; cin_i = 1'b1; sub_i = 1'b0;
      iv_m = 1'b1;
      tick();
      iv_m = 1'b0;
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_sum", s0, 0);
      check("midrst_cout", c0, 0);
      check("midrst_ovf", v0, 0);
      check("midrst_out_valid", ov0, 0);
      check("midrst_in_ready", ir0, 1);
      seen = '0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (ov0 === 1'b1) seen[0] = 1'b1;
      end
      check("midrst_no_result", seen[0], 0);

      // Random sweep over all four configurations in parallel
      for (int t = 0; t < 24; t++) begin
         a_i = $urandom; b_i = $urandom;
         cin_i = 1'($urandom_range(0, 1)); sub_i = 1'($urandom_range(0, 1));
         for (int k = 0; k < 4; k++) q[k].push_back(model(a_i, b_i, cin_i, sub_i, W[k]));
         iv_m = 1'b1; iv_s = 1'b1;
         tick();
         iv_m = 1'b0; iv_s = 1'b0;
         seen = '0;
         n = 0;
         while (seen != 4'hF && n < 40) begin
            tick();
            n++;
            for (int k = 0; k < 4; k++) begin
               if (ovv[k] === 1'b1 && !seen[k]) begin
                  seen[k] = 1'b1;
                  r = q[k].pop_front();
                  check($sformatf("sweep_lat_w%0d_n%0d", W[k], NC[k]), n, NC[k]);
                  check($sformatf("sweep_sum_w%0d_n%0d", W[k], NC[k]), sw[k], r.s);
                  check($sformatf("sweep_cout_w%0d_n%0d", W[k], NC[k]), cw[k], r.c);
                  check($sformatf("sweep_ovf_w%0d_n%0d", W[k], NC[k]), vw[k], r.v);
               end
            end
         end
         if (seen != 4'hF) check("sweep_timeout", seen, 4'hF);
         or_m = 1'b1; or_s = 1'b1;
         tick();
         or_m = 1'b0; or_s = 1'b0;
      end
      check("sweep_end_ready", {ir3, ir2, ir1, ir0}, 4'hF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
